// File: rtl/processing_unit_mc_if.sv
// processing_unit_mc_if: stage, syndrome, neighbor-link and
// context-switch signals of one decoder vertex.
interface processing_unit_mc_if #(
  parameter int ADDRESS_WIDTH  = 6,
  parameter int NEIGHBOR_COUNT = 6,
  parameter int NUM_CONTEXTS   = 4,
  parameter int STAGE_WIDTH    = 3
);
  localparam int CW = $clog2(NUM_CONTEXTS);
  localparam int ED = ADDRESS_WIDTH + 3;
  localparam int NW = NEIGHBOR_COUNT * ED;

  logic [STAGE_WIDTH-1:0]    global_stage;
  logic                      measurement;
  logic                      measurement_out;
  logic [ADDRESS_WIDTH-1:0]  input_address;
  logic [NEIGHBOR_COUNT-1:0] neighbor_fully_grown;
  logic [NEIGHBOR_COUNT-1:0] neighbor_is_boundary;
  logic [NEIGHBOR_COUNT-1:0] neighbor_increase;
  logic [NEIGHBOR_COUNT-1:0] neighbor_is_error;
  logic [NW-1:0]             input_data;
  logic [NW-1:0]             output_data;
  logic                      ctx_req;
  logic [CW-1:0]             ctx_next;
  logic                      ctx_local;
  logic                      ctx_done;
  logic [CW-1:0]             ctx_cur;
  logic [ADDRESS_WIDTH-1:0]  root;
  logic                      odd;
  logic                      busy;

  modport master (
    output global_stage, measurement, input_address,
    output neighbor_fully_grown, neighbor_is_boundary,
    output input_data, ctx_req, ctx_next, ctx_local,
    input  measurement_out, neighbor_increase,
    input  neighbor_is_error, output_data,
    input  ctx_done, ctx_cur, root, odd, busy
  );

  modport slave (
    input  global_stage, measurement, input_address,
    input  neighbor_fully_grown, neighbor_is_boundary,
    input  input_data, ctx_req, ctx_next, ctx_local,
    output measurement_out, neighbor_increase,
    output neighbor_is_error, output_data,
    output ctx_done, ctx_cur, root, odd, busy
  );
endinterface

// File: rtl/processing_unit_mc.sv
// processing_unit_mc: union-find decoder vertex with saved contexts.
// Define LOCAL_CTX_SWAP_EN for the single-cycle local port swap.
module processing_unit_mc #(
  parameter int ADDRESS_WIDTH  = 6,
  parameter int NEIGHBOR_COUNT = 6,
  parameter int NUM_CONTEXTS   = 4,
  parameter int SWAP_PORT_A    = 4,
  parameter int SWAP_PORT_B    = 5,
  parameter int STAGE_WIDTH    = 3
) (
  input logic                clk,
  input logic                reset,
  processing_unit_mc_if.slave bus
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int NC = NEIGHBOR_COUNT;
  localparam int CW = $clog2(NUM_CONTEXTS);
  localparam int ED = AW + 3;
  localparam int MW = 3 + NC + AW;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE =
    STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING =
    STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW =
    STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE =
    STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING =
    STAGE_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_FETCH,
    S_LOAD
  } state_t;

  state_t                 r_state;
  logic [STAGE_WIDTH-1:0] r_stage;
  logic [STAGE_WIDTH-1:0] r_last_stage;
  logic                   r_m;
  logic                   r_odd;
  logic                   r_cluster_parity;
  logic [AW-1:0]          r_root;
  logic [NC-1:0]          r_parent_vector;
  logic                   r_busy;
  logic [CW-1:0]          r_ctx_cur;
  logic [CW-1:0]          r_ctx_pend;
  logic                   r_ctx_done;
  logic [MW-1:0]          r_mem [NUM_CONTEXTS];
  logic [MW-1:0]          r_rd_data;

  logic [AW-1:0]    w_nb_root [NC];
  logic [NC-1:0]    w_nb_cp;
  logic [NC-1:0]    w_nb_podd;
  logic [NC-1:0]    w_nb_pbit;
  logic [NC-1:0]    w_bnd;
  logic [NC-1:0]    w_valid;
  logic             w_any_bnd;
  logic             w_any_valid;
  logic [AW-1:0]    w_min_root;
  logic [NC-1:0]    w_min_vec;
  logic [AW-1:0]    w_root_mod;
  logic [AW-1:0]    w_root_nx;
  logic [NC-1:0]    w_pv_nx;
  logic             w_next_parity;
  logic             w_odd_nx;
  logic             w_changed;
  logic [NC-1:0]    w_bnd_hi;
  logic [NC-1:0]    w_err;
  logic [NC*ED-1:0] w_out;
  logic             w_idle;
  logic             w_local_req;
  logic             w_unused;

  assign w_idle    = (r_state == S_IDLE);
  assign w_bnd     = bus.neighbor_is_boundary;
  assign w_any_bnd = |w_bnd;
  assign w_valid   = bus.neighbor_fully_grown & ~w_bnd;

`ifdef LOCAL_CTX_SWAP_EN
  assign w_local_req = bus.ctx_req & bus.ctx_local;
  assign w_unused    = bus.input_address[AW-1];
`else
  assign w_local_req = 1'b0;
  assign w_unused    = bus.ctx_local ^ bus.input_address[AW-1];
`endif

  // split the packed neighbor bus into per-link fields
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      w_nb_root[i] = bus.input_data[i*ED +: AW];
      w_nb_pbit[i] = bus.input_data[i*ED + AW];
      w_nb_podd[i] = bus.input_data[i*ED + AW + 1];
      w_nb_cp[i]   = bus.input_data[i*ED + AW + 2];
    end
  end

  // smallest root over grown non-boundary links; ties mark all
  always_comb begin
    w_min_root  = '1;
    w_any_valid = 1'b0;
    w_min_vec   = '0;
    for (int i = 0; i < NC; i++) begin
      if (w_valid[i] &&
          (!w_any_valid || w_nb_root[i] < w_min_root)) begin
        w_min_root  = w_nb_root[i];
        w_any_valid = 1'b1;
      end
    end
    for (int i = 0; i < NC; i++) begin
      w_min_vec[i] = w_valid[i] && (w_nb_root[i] == w_min_root);
    end
  end

  // a boundary link lets the vertex adopt its own boundary root
  assign w_root_mod = w_any_bnd ?
    {1'b0, bus.input_address[AW-2:0]} : r_root;

  // merge result: neighbor root, else boundary root, else hold
  always_comb begin
    w_root_nx = r_root;
    w_pv_nx   = r_parent_vector;
    if (w_any_valid && (w_min_root < r_root) &&
        (w_min_root < w_root_mod)) begin
      w_root_nx = w_min_root;
      w_pv_nx   = w_min_vec;
    end else if (w_root_mod < r_root) begin
      w_root_nx = w_root_mod;
      w_pv_nx   = '0;
    end
  end

  assign w_next_parity = (^(w_nb_pbit & w_nb_cp)) ^ r_m;
  assign w_odd_nx = (|r_parent_vector) ?
    |(r_parent_vector & w_nb_podd) :
    (w_next_parity & ~w_any_bnd);
  assign w_changed = (w_root_nx != r_root) ||
                     (w_pv_nx != r_parent_vector) ||
                     (w_next_parity != r_cluster_parity) ||
                     (w_odd_nx != r_odd);

  // one-hot of the highest-index boundary link
  always_comb begin
    w_bnd_hi = '0;
    for (int i = 0; i < NC; i++) begin
      if (w_bnd[i]) begin
        w_bnd_hi    = '0;
        w_bnd_hi[i] = 1'b1;
      end
    end
  end

  // peeling marks parent links, or the boundary when rootless
  always_comb begin
    w_err = '0;
    if (w_idle && (r_stage == STAGE_PEELING)) begin
      if (r_cluster_parity) begin
        w_err = w_err | r_parent_vector;
      end
      if ((r_parent_vector == '0) && w_next_parity) begin
        w_err = w_err | w_bnd_hi;
      end
    end
  end

  // every link sees the same state, plus its own parent bit
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      w_out[i*ED +: ED] = {r_cluster_parity, r_odd,
                           r_parent_vector[i], r_root};
    end
  end

  // stage tracking, stage-driven updates and context FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_stage          <= STAGE_IDLE;
      r_last_stage     <= STAGE_IDLE;
      r_m              <= 1'b0;
      r_odd            <= 1'b0;
      r_cluster_parity <= 1'b0;
      r_root           <= '0;
      r_parent_vector  <= '0;
      r_busy           <= 1'b0;
      r_ctx_cur        <= '0;
      r_ctx_pend       <= '0;
      r_ctx_done       <= 1'b0;
    end else begin
      r_stage      <= bus.global_stage;
      r_last_stage <= r_stage;
      r_ctx_done   <= 1'b0;
      r_busy       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_local_req) begin
            r_parent_vector[SWAP_PORT_A] <=
              r_parent_vector[SWAP_PORT_B];
            r_parent_vector[SWAP_PORT_B] <=
              r_parent_vector[SWAP_PORT_A];
            r_ctx_done <= 1'b1;
          end else begin
            if (bus.ctx_req) begin
              r_state    <= S_SAVE;
              r_ctx_pend <= bus.ctx_next;
            end
            if (r_stage == STAGE_MEASUREMENT_LOADING) begin
              r_m              <= bus.measurement;
              r_odd            <= bus.measurement;
              r_cluster_parity <= bus.measurement;
              r_root           <= bus.input_address;
              r_parent_vector  <= '0;
            end else if (r_stage == STAGE_MERGE) begin
              r_root           <= w_root_nx;
              r_parent_vector  <= w_pv_nx;
              r_cluster_parity <= w_next_parity;
              r_odd            <= w_odd_nx;
              r_busy           <= w_changed;
            end
          end
        end
        S_SAVE:  r_state <= S_FETCH;
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          {r_cluster_parity, r_parent_vector,
           r_root, r_odd, r_m} <= r_rd_data;
          r_ctx_cur  <= r_ctx_pend;
          r_ctx_done <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // context store: write current on SAVE, read target on FETCH
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_SAVE)) begin
      r_mem[r_ctx_cur] <= {r_cluster_parity, r_parent_vector,
                           r_root, r_odd, r_m};
    end
    if (r_state == S_FETCH) begin
      r_rd_data <= r_mem[r_ctx_pend];
    end
  end

  assign bus.neighbor_increase =
    (w_idle && (r_stage == STAGE_GROW) &&
     (r_last_stage != STAGE_GROW) && r_odd) ? '1 : '0;
  assign bus.neighbor_is_error = w_err;
  assign bus.output_data       = w_out;
  assign bus.measurement_out   = r_m;
  assign bus.root              = r_root;
  assign bus.odd               = r_odd;
  assign bus.busy              = r_busy | ~w_idle;
  assign bus.ctx_cur           = r_ctx_cur;
  assign bus.ctx_done          = r_ctx_done;
endmodule

// File: tb/tb_processing_unit_mc.sv
// tb_processing_unit_mc: directed vectors for processing_unit_mc,
// checked every cycle against a behavioural vertex model.
module tb_processing_unit_mc;
  localparam int AW = 6;
  localparam int NC = 6;
  localparam int NCTX = 4;
  localparam int SW = 3;
  localparam int CW = 2;
  localparam int ED = AW + 3;
  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_GROW  = 2;
  localparam int ST_MERGE = 3;
  localparam int ST_PEEL  = 4;
`ifdef LOCAL_CTX_SWAP_EN
  localparam bit LOCAL_EN = 1'b1;
`else
  localparam bit LOCAL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  processing_unit_mc_if #(
    .ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NC),
    .NUM_CONTEXTS(NCTX), .STAGE_WIDTH(SW)
  ) bus ();

  processing_unit_mc #(
    .ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NC),
    .NUM_CONTEXTS(NCTX), .SWAP_PORT_A(4),
    .SWAP_PORT_B(5), .STAGE_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  bit          started = 1'b0;
  int          nb_root [NC];
  bit [NC-1:0] nb_pbit, nb_podd, nb_cp;

  always_comb begin : pack_in
    logic [NC*ED-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++)
      v[i*ED +: ED] = {nb_cp[i], nb_podd[i], nb_pbit[i],
                       AW'(nb_root[i])};
    bus.input_data = v;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit f_np(input bit m);
    bit p = m;
    for (int i = 0; i < NC; i++) p ^= nb_pbit[i] & nb_cp[i];
    return p;
  endfunction

  function automatic logic [NC-1:0] f_hi(input logic [NC-1:0] b);
    for (int i = NC - 1; i >= 0; i--)
      if (b[i]) return NC'(1) << i;
    return '0;
  endfunction

  function automatic logic [NC-1:0] pv_out();
    logic [NC-1:0] p;
    for (int i = 0; i < NC; i++) p[i] = bus.output_data[i*ED+AW];
    return p;
  endfunction

  // behavioural model state
  int          md_stage, md_last, md_root, md_sw, md_cur, md_nxt;
  bit          md_m, md_odd, md_cp, md_busy, md_done, md_known;
  logic [NC-1:0] md_pv;
  int          mem_root [NCTX];
  logic [NC-1:0] mem_pv [NCTX];
  bit          mem_m [NCTX], mem_odd [NCTX], mem_cp [NCTX];
  bit          mem_k [NCTX] = '{default: 1'b0};

  always @(posedge clk) begin : model
    logic [NC-1:0] bnd, fg, mvec, npv;
    int mn, rmod, nroot;
    bit anyv, np, nodd, tmp;
    bnd = bus.neighbor_is_boundary;
    fg  = bus.neighbor_fully_grown;
    if (reset) begin
      md_stage = ST_IDLE; md_last = ST_IDLE; md_m = 0;
      md_odd = 0; md_cp = 0; md_root = 0; md_pv = '0;
      md_busy = 0; md_cur = 0; md_done = 0; md_sw = 0;
      md_known = 1;
    end else begin
      md_done = 0;
      md_busy = 0;
      case (md_sw)
        0: begin
          if (LOCAL_EN && bus.ctx_req && bus.ctx_local) begin
            tmp = md_pv[4]; md_pv[4] = md_pv[5]; md_pv[5] = tmp;
            md_done = 1;
          end else begin
            if (md_stage == ST_LOAD) begin
              md_m = bus.measurement; md_odd = bus.measurement;
              md_cp = bus.measurement;
              md_root = int'(bus.input_address); md_pv = '0;
              md_known = 1;
            end else if (md_stage == ST_MERGE) begin
              anyv = 0; mn = 0;
              for (int i = 0; i < NC; i++)
                if (fg[i] && !bnd[i] && (!anyv || nb_root[i] < mn)) begin
                  mn = nb_root[i]; anyv = 1;
                end
              mvec = '0;
              for (int i = 0; i < NC; i++)
                if (fg[i] && !bnd[i] && nb_root[i] == mn) mvec[i] = 1;
              rmod = (bnd != 0) ? int'(bus.input_address) % 32 : md_root;
              nroot = md_root; npv = md_pv;
              if (anyv && mn < md_root && mn < rmod) begin
                nroot = mn; npv = mvec;
              end else if (rmod < md_root) begin
                nroot = rmod; npv = '0;
              end
              np = f_np(md_m);
              nodd = (md_pv != 0) ? ((md_pv & nb_podd) != 0)
                                  : (np && bnd == 0);
              md_busy = (nroot != md_root) || (npv != md_pv) ||
                        (np != md_cp) || (nodd != md_odd);
              md_root = nroot; md_pv = npv; md_cp = np; md_odd = nodd;
            end
            if (bus.ctx_req) begin
              md_sw = 1; md_nxt = int'(bus.ctx_next);
            end
          end
        end
        1: begin
          mem_root[md_cur] = md_root; mem_pv[md_cur] = md_pv;
          mem_m[md_cur] = md_m; mem_odd[md_cur] = md_odd;
          mem_cp[md_cur] = md_cp; mem_k[md_cur] = md_known;
          md_sw = 2;
        end
        2: md_sw = 3;
        default: begin
          md_root = mem_root[md_nxt]; md_pv = mem_pv[md_nxt];
          md_m = mem_m[md_nxt]; md_odd = mem_odd[md_nxt];
          md_cp = mem_cp[md_nxt]; md_known = mem_k[md_nxt];
          md_cur = md_nxt; md_done = 1; md_sw = 0;
        end
      endcase
      md_last = md_stage;
      md_stage = int'(bus.global_stage);
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [NC*ED-1:0] eo;
    logic [NC-1:0] ee, ei;
    if (started) begin
      chk("ctx_cur", bus.ctx_cur, md_cur);
      chk("ctx_done", bus.ctx_done, md_done);
      if (md_known) begin
        for (int i = 0; i < NC; i++)
          eo[i*ED +: ED] = {md_cp, md_odd, md_pv[i], AW'(md_root)};
        ei = (md_sw == 0 && md_stage == ST_GROW &&
              md_last != ST_GROW && md_odd) ? '1 : '0;
        ee = '0;
        if (md_sw == 0 && md_stage == ST_PEEL) begin
          if (md_cp) ee |= md_pv;
          if (md_pv == 0 && f_np(md_m))
            ee |= f_hi(bus.neighbor_is_boundary);
        end
        chk("root", bus.root, md_root);
        chk("odd", bus.odd, md_odd);
        chk("busy", bus.busy, md_busy || md_sw != 0);
        chk("meas_out", bus.measurement_out, md_m);
        chk("increase", bus.neighbor_increase, ei);
        chk("is_error", bus.neighbor_is_error, ee);
        chk("output_data", bus.output_data, eo);
      end else if (md_sw != 0) begin
        chk("busy_sw", bus.busy, 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_switch(input int nxt, input bit loc,
                           output int nb, output int nd);
    bus.ctx_next = CW'(nxt);
    bus.ctx_local = loc;
    bus.ctx_req = 1'b1;
    tick(1);
    bus.ctx_req = 1'b0;
    bus.ctx_local = 1'b0;
    nb = 0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.busy) nb++;
      if (bus.ctx_done) nd++;
      if (k < 5) tick(1);
    end
  endtask

  task automatic clear_nb();
    for (int i = 0; i < NC; i++) nb_root[i] = 0;
    nb_pbit = '0; nb_podd = '0; nb_cp = '0;
    bus.neighbor_fully_grown = '0;
    bus.neighbor_is_boundary = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int nb, nd;
    bus.global_stage = '0; bus.measurement = 0;
    bus.input_address = '0; bus.ctx_req = 0;
    bus.ctx_next = '0; bus.ctx_local = 0;
    clear_nb();
    tick(3);
    reset = 1'b0;
    started = 1'b1;
    chk("rst_root", bus.root, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ctx_cur", bus.ctx_cur, 0);
    chk("rst_ctx_done", bus.ctx_done, 0);
    chk("rst_increase", bus.neighbor_increase, 0);
    chk("rst_meas", bus.measurement_out, 0);

    // growth request on the first grow cycle only
    bus.measurement = 1; bus.input_address = 5;
    bus.global_stage = ST_LOAD; tick(1);
    bus.global_stage = ST_GROW; tick(1);
    chk("grow_first", bus.neighbor_increase, 6'h3f);
    chk("load_root", bus.root, 5);
    tick(1);
    chk("grow_second", bus.neighbor_increase, 0);

    // boundary merge then peel toward highest boundary link
    bus.global_stage = ST_LOAD; bus.input_address = 6'b100101;
    bus.measurement = 1; tick(1);
    bus.global_stage = ST_MERGE;
    bus.neighbor_is_boundary = 6'b000100; tick(2);
    chk("bnd_root", bus.root, 6'b000101);
    chk("bnd_odd", bus.odd, 0);
    chk("bnd_pv", pv_out(), 0);
    bus.global_stage = ST_PEEL; tick(1);
    chk("peel_bnd", bus.neighbor_is_error, 6'b000100);
    bus.neighbor_is_boundary = 6'b100100; tick(1);
    chk("peel_bnd_hi", bus.neighbor_is_error, 6'b100000);
    clear_nb();

    // neighbor merge with a tie on ports 1 and 2
    bus.global_stage = ST_LOAD; bus.input_address = 7;
    bus.measurement = 0;
    nb_root = '{9, 3, 3, 1, 1, 1};
    bus.neighbor_fully_grown = 6'b000111; tick(1);
    bus.global_stage = ST_MERGE; tick(2);
    chk("merge_root", bus.root, 3);
    chk("merge_pv", pv_out(), 6'b000110);
    chk("merge_busy", bus.busy, 1);
    tick(1);
    chk("merge_idle_busy", bus.busy, 0);
    chk("merge_hold_root", bus.root, 3);
    nb_podd = 6'b000010; nb_pbit = 6'b001000; nb_cp = 6'b001000;
    tick(1);
    chk("merge_odd", bus.odd, 1);
    chk("merge_par_busy", bus.busy, 1);
    bus.global_stage = ST_PEEL; tick(1);
    chk("peel_parent", bus.neighbor_is_error, 6'b000110);
    bus.global_stage = ST_IDLE; tick(2);

    // context round trip
    do_switch(1, 0, nb, nd);
    chk("sw1_busy_cycles", nb, 3);
    chk("sw1_done_pulses", nd, 1);
    chk("sw1_ctx_cur", bus.ctx_cur, 1);
    bus.global_stage = ST_LOAD; bus.input_address = 12;
    bus.measurement = 0; tick(1);
    bus.global_stage = ST_IDLE; tick(2);
    chk("ctx1_root", bus.root, 12);
    do_switch(0, 0, nb, nd);
    chk("sw0_root", bus.root, 3);
    chk("sw0_busy_cycles", nb, 3);
    chk("sw0_done_pulses", nd, 1);
    chk("sw0_ctx_cur", bus.ctx_cur, 0);
    do_switch(1, 0, nb, nd);
    chk("sw1b_root", bus.root, 12);
    do_switch(1, 0, nb, nd);
    chk("same_root", bus.root, 12);
    chk("same_busy_cycles", nb, 3);
    chk("same_done_pulses", nd, 1);
    do_switch(0, 1, nb, nd);
    if (LOCAL_EN) begin
      chk("loc_ctx_cur", bus.ctx_cur, 1);
      chk("loc_root", bus.root, 12);
      chk("loc_busy_cycles", nb, 0);
    end else begin
      chk("noloc_ctx_cur", bus.ctx_cur, 0);
      chk("noloc_root", bus.root, 3);
      chk("noloc_busy_cycles", nb, 3);
    end
    chk("loc_done_pulses", nd, 1);

    // reset during FETCH; request held high meanwhile
    bus.ctx_next = 2; bus.ctx_req = 1; tick(2);
    reset = 1'b1; tick(1);
    reset = 1'b0; bus.ctx_req = 0;
    chk("abort_ctx_cur", bus.ctx_cur, 0);
    chk("abort_busy", bus.busy, 0);
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.ctx_done) nd++;
      tick(1);
    end
    chk("abort_no_done", nd, 0);

`ifdef LOCAL_CTX_SWAP_EN
    clear_nb();
    bus.global_stage = ST_LOAD; bus.input_address = 20;
    bus.measurement = 0; tick(1);
    nb_root[4] = 2; bus.neighbor_fully_grown = 6'b010000;
    bus.global_stage = ST_MERGE; tick(2);
    bus.global_stage = ST_IDLE; tick(2);
    chk("swap_pre_pv", pv_out(), 6'b010000);
    do_switch(3, 1, nb, nd);
    chk("swap_pv", pv_out(), 6'b100000);
    chk("swap_ctx_cur", bus.ctx_cur, 0);
    chk("swap_done", nd, 1);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
